// File: rtl/rv_spi_flash_rd.sv
// rv_spi_flash_rd: autonomous serial-flash READ master that drives the SPI peripheral's register bus.
// Define SPI_FLASH_FAST_READ_EN to issue FAST READ (0x0B plus one dummy byte) instead of READ (0x03).
module rv_spi_flash_rd #(
    parameter logic [7:0]  N_BRC    = 8'd3,
    parameter logic [7:0]  R_BRC    = 8'd2,
    parameter int unsigned START_TO = 64,
    parameter int unsigned DRAIN    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [3:0]  len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic [4:0]  spi_adr,
    output logic        spi_cs,
    output logic        spi_rdy,
    output logic [3:0]  spi_we,
    output logic        spi_re,
    output logic [31:0] spi_dw,
    input  logic [31:0] spi_dr
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam logic [3:0] H   = 4'd5;
`else
    localparam logic [7:0] CMD = 8'h03;
    localparam logic [3:0] H   = 4'd4;
`endif
    // Frame (H + len) must fit the 16-entry FIFO.
    localparam logic [3:0] MAX_LEN = 4'd15 - H + 4'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_ARM, S_PUSH, S_WSTART,
        S_WEND, S_DRAIN, S_CSOFF, S_RD, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q;
    logic [3:0]  len_q;
    logic        err_q;
    logic [3:0]  k;
    logic [3:0]  w;
    logic [2:0]  ph;
    logic [15:0] cnt;
    logic [31:0] word_q;

    logic        len_ok;
    logic [3:0]  last_k;
    logic [3:0]  first_w;
    logic [3:0]  last_w;
    logic        to_hit;
    logic        drain_hit;
    logic [1:0]  bsel;
    logic [3:0]  bidx;
    logic [7:0]  frame_byte;
    logic [7:0]  word_byte;

    assign len_ok    = (len != 4'd0) && (len <= MAX_LEN);
    assign last_k    = H + len_q - 4'd1;
    assign first_w   = {2'b00, H[3:2]};
    assign last_w    = {2'b00, last_k[3:2]};
    assign to_hit    = (cnt == 16'(START_TO - 1));
    assign drain_hit = (cnt == 16'(DRAIN - 1));
    assign bsel      = 2'(ph - 3'd2);
    assign bidx      = {w[1:0], bsel};

    always_comb begin
        case (k)
            4'd0:    frame_byte = CMD;
            4'd1:    frame_byte = addr_q[23:16];
            4'd2:    frame_byte = addr_q[15:8];
            4'd3:    frame_byte = addr_q[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        case (bsel)
            2'd0:    word_byte = word_q[7:0];
            2'd1:    word_byte = word_q[15:8];
            2'd2:    word_byte = word_q[23:16];
            default: word_byte = word_q[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req) state_d = len_ok ? S_CFG : S_DONE;
            S_CFG:    state_d = S_ARM;
            S_ARM:    state_d = S_PUSH;
            S_PUSH:   if (k == last_k) state_d = S_WSTART;
            S_WSTART: begin
                if (ph[0] && spi_dr[9]) state_d = S_WEND;
                else if (to_hit)        state_d = S_CSOFF;
            end
            S_WEND:   if (ph[0] && !spi_dr[9]) state_d = S_DRAIN;
            S_DRAIN:  if (drain_hit) state_d = S_CSOFF;
            S_CSOFF:  state_d = err_q ? S_DONE : S_RD;
            S_RD:     if (ph == 3'd5 && w == last_w) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Sub-counters restart on every state change so each state sees a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            k      <= '0;
            w      <= '0;
            ph     <= '0;
            cnt    <= '0;
            word_q <= '0;
        end else begin
            if (state_q == S_IDLE && req) begin
                err_q <= !len_ok;
                if (len_ok) begin
                    addr_q <= addr;
                    len_q  <= len;
                end
            end
            if (state_q == S_WSTART && state_d == S_CSOFF) err_q <= 1'b1;
            if (state_q == S_RD && ph == 3'd1) word_q <= spi_dr;
            if (state_d != state_q) begin
                k   <= '0;
                ph  <= '0;
                cnt <= '0;
                w   <= first_w;
            end else begin
                if (state_q == S_PUSH) k <= k + 4'd1;
                if (state_q == S_WSTART || state_q == S_DRAIN) cnt <= cnt + 16'd1;
                if (state_q == S_WSTART || state_q == S_WEND) ph <= {2'b00, ~ph[0]};
                if (state_q == S_RD) begin
                    if (ph == 3'd5) begin
                        ph <= '0;
                        w  <= w + 4'd1;
                    end else begin
                        ph <= ph + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = 1'b0;
        err      = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        spi_adr  = '0;
        spi_cs   = 1'b0;
        spi_we   = '0;
        spi_re   = 1'b0;
        spi_dw   = '0;
        case (state_q)
            S_CFG: begin
                spi_cs = 1'b1;
                spi_we = 4'b1110;
                spi_dw = {N_BRC, R_BRC, 6'b0, 1'b1, 1'b1, 8'h00};
            end
            S_ARM: begin
                spi_cs = 1'b1;
                spi_we = 4'b0010;
            end
            S_PUSH: begin
                spi_cs = 1'b1;
                spi_we = 4'b0001;
                spi_dw = {24'h0, frame_byte};
            end
            S_WSTART, S_WEND: begin
                if (!ph[0]) begin
                    spi_cs = 1'b1;
                    spi_re = 1'b1;
                end
            end
            S_CSOFF: begin
                spi_cs = 1'b1;
                spi_we = 4'b0010;
                spi_dw = 32'h0000_0100;
            end
            S_RD: begin
                if (ph == 3'd0) begin
                    spi_cs  = 1'b1;
                    spi_re  = 1'b1;
                    spi_adr = {w[2:0] + 3'd1, 2'b00};
                end else if (ph >= 3'd2 && bidx >= H && bidx <= last_k) begin
                    rd_valid = 1'b1;
                    rd_data  = word_byte;
                end
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
        spi_rdy = spi_cs;
    end

endmodule

// File: tb/tb_rv_spi_flash_rd.sv
// Directed bench for rv_spi_flash_rd with a small SPI peripheral model (register reads, txen, RX FIFO words).
module tb_rv_spi_flash_rd;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [23:0] addr;
    logic [3:0]  len;
    logic        busy, done, err, rd_valid;
    logic [7:0]  rd_data;
    logic [4:0]  spi_adr;
    logic        spi_cs, spi_rdy, spi_re;
    logic [3:0]  spi_we;
    logic [31:0] spi_dw;
    logic [31:0] spi_dr = '0;

    rv_spi_flash_rd #(
        .N_BRC(8'd3), .R_BRC(8'd2), .START_TO(64), .DRAIN(32)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .len(len),
        .busy(busy), .done(done), .err(err), .rd_valid(rd_valid), .rd_data(rd_data),
        .spi_adr(spi_adr), .spi_cs(spi_cs), .spi_rdy(spi_rdy), .spi_we(spi_we),
        .spi_re(spi_re), .spi_dw(spi_dw), .spi_dr(spi_dr)
    );

    always #5 clk = ~clk;

    // Peripheral model and bus log, sampled on the falling edge.
    logic [7:0]   rx [16];
    logic         tx_mode;
    int           polls = 0, cs_n = 0, push_n = 0, rd_n = 0, rdadr_n = 0;
    int           csoff_n = 0, done_n = 0, idle_bad = 0, mw;
    logic         scs = 1'b0;
    logic [3:0]   first_we = '0;
    logic [31:0]  cfg_dw = '0;
    logic [31:0]  rdadr_pack = '0;
    logic [127:0] push_pack = '0, rd_pack = '0;

    always @(negedge clk) begin
        if (req && !busy) begin
            polls <= 0; cs_n <= 0; push_n <= 0; rd_n <= 0; rdadr_n <= 0;
            csoff_n <= 0; done_n <= 0; first_we <= '0; cfg_dw <= '0;
            rdadr_pack <= '0; push_pack <= '0; rd_pack <= '0;
        end else begin
            if (spi_rdy != spi_cs) idle_bad <= idle_bad + 1;
            if (spi_cs) begin
                cs_n <= cs_n + 1;
                if (cs_n == 0) first_we <= spi_we;
                if (spi_we == 4'b1110) begin
                    cfg_dw <= spi_dw;
                    polls  <= 0;
                end
                if (spi_we[1]) scs <= spi_dw[8];
                if (spi_we == 4'b0010 && spi_dw[8]) csoff_n <= csoff_n + 1;
                if (spi_we == 4'b0001) begin
                    push_pack <= {push_pack[119:0], spi_dw[7:0]};
                    push_n    <= push_n + 1;
                end
                if (spi_re) begin
                    if (spi_adr == 5'd0) begin
                        spi_dr <= {22'h0, tx_mode && polls >= 2 && polls < 5, 9'h0};
                        polls  <= polls + 1;
                    end else begin
                        mw = int'(spi_adr[4:2]) - 1;
                        if (mw < 0 || mw > 3) mw = 0;
                        spi_dr <= {rx[4*mw+3], rx[4*mw+2], rx[4*mw+1], rx[4*mw]};
                        rdadr_pack <= {rdadr_pack[23:0], 3'b000, spi_adr};
                        rdadr_n    <= rdadr_n + 1;
                    end
                end
            end else if (spi_we != 4'd0 || spi_re || spi_adr != 5'd0 || spi_dw != 32'd0) begin
                idle_bad <= idle_bad + 1;
            end
            if (rd_valid) begin
                rd_pack <= {rd_pack[119:0], rd_data};
                rd_n    <= rd_n + 1;
            end
            if (done) done_n <= done_n + 1;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic run(input logic [23:0] a, input logic [3:0] n, output int cyc, output logic b0);
        @(posedge clk); #1;
        addr = a; len = n; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        b0  = busy;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    function automatic logic [55:0] outs();
        return {busy, done, err, rd_valid, rd_data, spi_adr, spi_cs, spi_rdy,
                spi_we, spi_re, spi_dw};
    endfunction

    int   cyc, c;
    logic b0;

    initial begin
        reset = 1'b1; req = 1'b0; addr = '0; len = '0; tx_mode = 1'b1;
        for (int i = 0; i < 16; i++) rx[i] = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 128'(outs()), 128'h0);
        reset = 1'b0;

`ifndef SPI_FLASH_FAST_READ_EN
        rx[4] = 8'hA0; rx[5] = 8'hA1; rx[6] = 8'hA2; rx[7] = 8'hA3;
        run(24'h123456, 4'd4, cyc, b0);
        check("t1_busy", 128'(b0), 128'h1);
        check("t1_done", 128'(done), 128'h1);
        check("t1_err", 128'(err), 128'h0);
        check("t1_cfg_dw", 128'(cfg_dw), 128'h0302_0300);
        check("t1_push_n", 128'(push_n), 128'd8);
        check("t1_push", push_pack, 128'h0312_3456_0000_0000);
        check("t1_rdadr_n", 128'(rdadr_n), 128'd1);
        check("t1_rdadr", 128'(rdadr_pack), 128'h08);
        check("t1_rd_n", 128'(rd_n), 128'd4);
        check("t1_rd", rd_pack, 128'hA0A1_A2A3);
        @(posedge clk); #1;
        check("t1_done_1cyc", 128'(done), 128'h0);

        for (int i = 0; i < 16; i++) rx[i] = 8'h40 + 8'(i);
        run(24'hABCDEF, 4'd12, cyc, b0);
        check("t2_done", 128'(done), 128'h1);
        check("t2_err", 128'(err), 128'h0);
        check("t2_push_n", 128'(push_n), 128'd16);
        check("t2_push_hdr", 128'(push_pack[127:96]), 128'h03AB_CDEF);
        check("t2_push_pad", 128'(push_pack[95:0]), 128'h0);
        check("t2_rdadr_n", 128'(rdadr_n), 128'd3);
        check("t2_rdadr", 128'(rdadr_pack[23:0]), 128'h080C10);
        check("t2_rd_n", 128'(rd_n), 128'd12);
        check("t2_rd", rd_pack, 128'h4445_4647_4849_4A4B_4C4D_4E4F);
        check("t2_scs", 128'(scs), 128'h1);
`else
        for (int i = 0; i < 16; i++) rx[i] = 8'h40 + 8'(i);
        run(24'h000010, 4'd3, cyc, b0);
        check("f_done", 128'(done), 128'h1);
        check("f_err", 128'(err), 128'h0);
        check("f_push_n", 128'(push_n), 128'd8);
        check("f_push", push_pack, 128'h0B00_0010_0000_0000);
        check("f_rdadr", 128'(rdadr_pack), 128'h08);
        check("f_rd_n", 128'(rd_n), 128'd3);
        check("f_rd", rd_pack, 128'h45_4647);
        run(24'h000000, 4'd12, cyc, b0);
        check("f_len12_next", 128'(cyc), 128'd0);
        check("f_len12_err", 128'({done, err}), 128'h3);
        check("f_len12_cs", 128'(cs_n), 128'd0);
`endif

        run(24'h111111, 4'd0, cyc, b0);
        check("len0_next", 128'(cyc), 128'd0);
        check("len0_done_err", 128'({done, err}), 128'h3);
        check("len0_cs", 128'(cs_n), 128'd0);
        run(24'h222222, 4'd13, cyc, b0);
        check("len13_next", 128'(cyc), 128'd0);
        check("len13_done_err", 128'({done, err}), 128'h3);
        check("len13_cs", 128'(cs_n), 128'd0);

        tx_mode = 1'b0;
        run(24'h000200, 4'd2, cyc, b0);
        check("to_done", 128'(done), 128'h1);
        check("to_err", 128'(err), 128'h1);
        check("to_polls", 128'(polls), 128'd32);
        check("to_csoff", 128'(csoff_n), 128'd1);
        check("to_rd_n", 128'(rd_n), 128'd0);
        check("to_scs", 128'(scs), 128'h1);
        tx_mode = 1'b1;

        @(posedge clk); #1;
        addr = 24'h0; len = 4'd2; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        c = 0;
        while (polls < 4 && c < 200) begin
            @(negedge clk); #1;
            c++;
        end
        check("rst_wend_reached", 128'(polls), 128'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_outs", 128'(outs()), 128'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", 128'(done_n), 128'd0);
        rx[4] = 8'h5A;
        run(24'h000100, 4'd1, cyc, b0);
        check("rst_first_cfg", 128'(first_we), 128'hE);
        check("rst_done_err", 128'({done, err}), 128'h2);
        check("rst_rd_n", 128'(rd_n), 128'd1);
        check("rst_rd", 128'(rd_pack[7:0]), 128'h5A);

        check("bus_idle_zero", 128'(idle_bad), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
